// File: rtl/ahb_slave_wrr_arbiter_pkg.sv
// Shared AHB types and helpers for the weighted round-robin slave arbiter.
package ahb_slave_wrr_arbiter_pkg;

  localparam int unsigned BEAT_W = 5;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST
  } arb_state_t;

  // Fixed-length bursts return their beat count; open INCR returns 0 so the
  // caller can substitute its own cap.
  function automatic logic [BEAT_W-1:0] beats_of(hburst_type b);
    logic [BEAT_W-1:0] n;
    n = '0;
    unique case (b)
      HB_SINGLE:           n = 5'd1;
      HB_INCR4, HB_WRAP4:  n = 5'd4;
      HB_INCR8, HB_WRAP8:  n = 5'd8;
      HB_INCR16, HB_WRAP16: n = 5'd16;
      default:             n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_slave_wrr_arbiter_if.sv
// Request/grant and owner-transfer signals between masters and the arbiter.
interface ahb_slave_wrr_arbiter_if #(
  parameter int unsigned MASTER_NUM = 4
);
  import ahb_slave_wrr_arbiter_pkg::*;

  localparam int unsigned MW = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0] hreq;
  logic [MASTER_NUM-1:0] hlock;
  htrans_type            htrans_m;
  hburst_type            hburst_m;
  logic                  hready;
  logic [MASTER_NUM-1:0] hgrant;
  logic [MW-1:0]         hmaster;
  logic                  hmastlock;
  logic                  hsel;

  modport slave (
    input  hreq, hlock, htrans_m, hburst_m, hready,
    output hgrant, hmaster, hmastlock, hsel
  );

  modport master (
    output hreq, hlock, htrans_m, hburst_m, hready,
    input  hgrant, hmaster, hmastlock, hsel
  );

endinterface

// File: rtl/ahb_slave_wrr_arbiter_wrr_pick.sv
// Round-robin picker: first set request at or above i_ptr, wrapping around.
module ahb_slave_wrr_arbiter_wrr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_index,
  output logic          o_valid
);

  logic [IW-1:0] w_idx;

  always_comb begin
    o_onehot = '0;
    o_index  = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = IW'((32'(i_ptr) + k) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_valid         = 1'b1;
        o_onehot[w_idx] = 1'b1;
        o_index         = w_idx;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_wrr_arbiter.sv
// Per-slave AHB arbiter: weighted round-robin with burst-aware grant holding,
// lock retention, INCR beat cap and a no-show timeout for new owners.
module ahb_slave_wrr_arbiter
  import ahb_slave_wrr_arbiter_pkg::*;
#(
  parameter int unsigned               MASTER_NUM     = 4,
  parameter logic [4*MASTER_NUM-1:0]   WEIGHT         = {MASTER_NUM{4'd1}},
  parameter int unsigned               MAX_INCR_BEATS = 16,
  parameter int unsigned               ADDR_TIMEOUT   = 8
) (
  input logic                    hclk,
  input logic                    hreset_n,
  ahb_slave_wrr_arbiter_if.slave bus
);

  localparam int unsigned MW = $clog2(MASTER_NUM);
  localparam int unsigned TW = $clog2(ADDR_TIMEOUT + 1);

  arb_state_t            r_state, w_state_nxt;
  logic [MASTER_NUM-1:0] r_grant, w_grant_nxt;
  logic [MW-1:0]         r_master, w_master_nxt;
  logic                  r_mastlock, w_mastlock_nxt;
  logic [MW-1:0]         r_ptr, w_ptr_nxt;
  logic [3:0]            r_credit, w_credit_nxt;
  logic [BEAT_W-1:0]     r_beats, w_beats_nxt;
  logic [TW-1:0]         r_tout, w_tout_nxt;

  logic                  w_owner_req;
  logic                  w_owner_lock;
  logic [3:0]            w_credit_dec;
  logic [MW-1:0]         w_ptr_adv;
  logic [BEAT_W-1:0]     w_burst_beats;
  logic [BEAT_W-1:0]     w_load;
  logic                  w_nonseq;
  logic                  w_event;
  logic                  w_revoke;
  logic                  w_retain;
  logic [MASTER_NUM-1:0] w_pick_req;
  logic [MW-1:0]         w_pick_ptr;
  logic [MASTER_NUM-1:0] w_pick_onehot;
  logic [MW-1:0]         w_pick_index;
  logic                  w_pick_valid;

  assign w_owner_req   = bus.hreq[r_master];
  assign w_owner_lock  = bus.hlock[r_master];
  assign w_credit_dec  = (r_credit != '0) ? r_credit - 4'd1 : '0;
  assign w_ptr_adv     = (r_master == MW'(MASTER_NUM - 1)) ? '0 : r_master + 1'b1;
  assign w_burst_beats = beats_of(bus.hburst_m);
  assign w_load        = (w_burst_beats == '0) ? BEAT_W'(MAX_INCR_BEATS) : w_burst_beats;

  // Decode the re-arbitration event for the current owner.
  always_comb begin
    w_nonseq = 1'b0;
    w_event  = 1'b0;
    w_revoke = 1'b0;
    if (bus.hready) begin
      unique case (r_state)
        ST_ADDR: begin
          if (bus.htrans_m == HT_NONSEQ) begin
            w_nonseq = 1'b1;
            w_event  = (bus.hburst_m == HB_SINGLE);
          end else if ((bus.htrans_m == HT_IDLE && !w_owner_req) ||
                       (r_tout >= TW'(ADDR_TIMEOUT - 1))) begin
            w_event  = 1'b1;
            w_revoke = 1'b1;
          end
        end
        ST_BURST: begin
          unique case (bus.htrans_m)
            HT_SEQ:    w_event = (r_beats == 5'd1);
            HT_NONSEQ: begin
              w_event  = 1'b1;
              w_nonseq = 1'b1;
            end
            HT_IDLE:   w_event = 1'b1;
            default:   w_event = 1'b0;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign w_retain = w_event && !w_revoke &&
                    (w_owner_lock || (w_owner_req && w_credit_dec != '0));

  // A revoked owner is masked out so it cannot win straight back.
  assign w_pick_req = w_revoke ? (bus.hreq & ~r_grant) : bus.hreq;
  assign w_pick_ptr = (r_state == ST_IDLE) ? r_ptr : w_ptr_adv;

  ahb_slave_wrr_arbiter_wrr_pick #(
    .N  (MASTER_NUM),
    .IW (MW)
  ) u_pick (
    .i_req    (w_pick_req),
    .i_ptr    (w_pick_ptr),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_index),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_master_nxt   = r_master;
    w_mastlock_nxt = r_mastlock;
    w_ptr_nxt      = r_ptr;
    w_credit_nxt   = r_credit;
    w_beats_nxt    = r_beats;
    w_tout_nxt     = r_tout;
    if (bus.hready) begin
      if (r_state == ST_IDLE || (w_event && !w_retain)) begin
        if (r_state != ST_IDLE) begin
          w_ptr_nxt = w_ptr_adv;
        end
        w_beats_nxt = '0;
        w_tout_nxt  = '0;
        if (w_pick_valid) begin
          w_state_nxt    = ST_ADDR;
          w_grant_nxt    = w_pick_onehot;
          w_master_nxt   = w_pick_index;
          w_credit_nxt   = WEIGHT[4*w_pick_index +: 4];
          w_mastlock_nxt = bus.hlock[w_pick_index];
        end else begin
          w_state_nxt    = ST_IDLE;
          w_grant_nxt    = '0;
          w_mastlock_nxt = 1'b0;
          w_credit_nxt   = '0;
        end
      end else if (w_event) begin
        if (!w_owner_lock) begin
          w_credit_nxt = w_credit_dec;
        end
        w_tout_nxt = '0;
        if (w_nonseq) begin
          w_mastlock_nxt = w_owner_lock;
        end
        // A retained NONSEQ inside a burst starts the next burst immediately.
        if (w_nonseq && r_state == ST_BURST && w_load > 5'd1) begin
          w_state_nxt = ST_BURST;
          w_beats_nxt = w_load - 5'd1;
        end else begin
          w_state_nxt = ST_ADDR;
          w_beats_nxt = '0;
        end
      end else if (r_state == ST_ADDR) begin
        if (w_nonseq) begin
          w_state_nxt    = ST_BURST;
          w_beats_nxt    = w_load - 5'd1;
          w_mastlock_nxt = w_owner_lock;
          w_tout_nxt     = '0;
        end else begin
          w_tout_nxt = r_tout + 1'b1;
        end
      end else if (bus.htrans_m == HT_SEQ) begin
        w_beats_nxt = r_beats - 5'd1;
      end
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_master   <= '0;
      r_mastlock <= 1'b0;
      r_ptr      <= '0;
      r_credit   <= '0;
      r_beats    <= '0;
      r_tout     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_master   <= w_master_nxt;
      r_mastlock <= w_mastlock_nxt;
      r_ptr      <= w_ptr_nxt;
      r_credit   <= w_credit_nxt;
      r_beats    <= w_beats_nxt;
      r_tout     <= w_tout_nxt;
    end
  end

  assign bus.hgrant    = r_grant;
  assign bus.hmaster   = r_master;
  assign bus.hmastlock = r_mastlock;
  assign bus.hsel      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ahb_slave_wrr_arbiter.sv
// Directed bench for ahb_slave_wrr_arbiter: equal weights on u_dut_a, master 0 weighted 3 on u_dut_b.
module tb_ahb_slave_wrr_arbiter;
  import ahb_slave_wrr_arbiter_pkg::*;

  logic       hclk = 1'b0;
  logic       hreset_n = 1'b0;
  logic [3:0] hreq;
  logic [3:0] hlock;
  htrans_type htrans;
  hburst_type hburst;
  logic       hready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 hclk = ~hclk;

  ahb_slave_wrr_arbiter_if #(.MASTER_NUM(4)) bus_a ();
  ahb_slave_wrr_arbiter_if #(.MASTER_NUM(4)) bus_b ();

  assign bus_a.hreq     = hreq;
  assign bus_a.hlock    = hlock;
  assign bus_a.htrans_m = htrans;
  assign bus_a.hburst_m = hburst;
  assign bus_a.hready   = hready;
  assign bus_b.hreq     = hreq;
  assign bus_b.hlock    = hlock;
  assign bus_b.htrans_m = htrans;
  assign bus_b.hburst_m = hburst;
  assign bus_b.hready   = hready;

  ahb_slave_wrr_arbiter #(
    .MASTER_NUM     (4),
    .WEIGHT         (16'h1111),
    .MAX_INCR_BEATS (16),
    .ADDR_TIMEOUT   (8)
  ) u_dut_a (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus_a)
  );

  ahb_slave_wrr_arbiter #(
    .MASTER_NUM     (4),
    .WEIGHT         (16'h1113),
    .MAX_INCR_BEATS (16),
    .ADDR_TIMEOUT   (8)
  ) u_dut_b (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] oh(input int i);
    return 32'd1 << i;
  endfunction

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic apply_reset();
    hreq     = '0;
    hlock    = '0;
    htrans   = HT_IDLE;
    hburst   = HB_SINGLE;
    hready   = 1'b1;
    hreset_n = 1'b0;
    cyc();
    hreset_n = 1'b1;
  endtask

  htrans_type  t4_tr [12];
  logic [11:0] t4_rdy;

  initial begin
    int cur;
    int ex;

    // Reset values
    apply_reset();
    check("rst_grant", bus_a.hgrant, 0);
    check("rst_master", bus_a.hmaster, 0);
    check("rst_lock", bus_a.hmastlock, 0);
    check("rst_hsel", bus_a.hsel, 0);
    check("rst_grant_b", bus_b.hgrant, 0);

    // Single request: grant one cycle later
    hreq = 4'b0100;
    cyc();
    check("t1_grant", bus_a.hgrant, 4'b0100);
    check("t1_master", bus_a.hmaster, 2);
    check("t1_hsel", bus_a.hsel, 1);

    // Two masters, INCR4, equal weights: alternate, handover on 4th beat
    apply_reset();
    hreq   = 4'b0011;
    hburst = HB_INCR4;
    cyc();
    check("t2_first", bus_a.hgrant, 4'b0001);
    cur = 0;
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 4; b++) begin
        htrans = (b == 0) ? HT_NONSEQ : HT_SEQ;
        cyc();
        ex = (b == 3) ? 1 - cur : cur;
        check("t2_grant", bus_a.hgrant, oh(ex));
        check("t2_master", bus_a.hmaster, ex);
      end
      cur = 1 - cur;
    end

    // Weighted: master 0 (weight 3) vs master 2, back-to-back SINGLEs
    apply_reset();
    hreq   = 4'b0101;
    hburst = HB_SINGLE;
    cyc();
    check("t3_first", bus_b.hgrant, 4'b0001);
    htrans = HT_NONSEQ;
    for (int k = 0; k < 8; k++) begin
      cyc();
      ex = (((k + 1) % 4) == 3) ? 2 : 0;
      check("t3_grant", bus_b.hgrant, oh(ex));
    end

    // INCR8 with a 3-cycle stall and one BUSY: held until 8th accepted beat
    apply_reset();
    hreq   = 4'b0011;
    hburst = HB_INCR8;
    cyc();
    t4_tr  = '{HT_NONSEQ, HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ,
               HT_SEQ, HT_BUSY, HT_SEQ, HT_SEQ, HT_SEQ, HT_SEQ};
    t4_rdy = 12'hFC7;
    for (int i = 0; i < 12; i++) begin
      htrans = t4_tr[i];
      hready = t4_rdy[i];
      cyc();
      check("t4_grant", bus_a.hgrant, (i == 11) ? 4'b0010 : 4'b0001);
    end

    // Lock: master 1 retained across a final beat, then loses to master 3
    apply_reset();
    hreq   = 4'b1010;
    hlock  = 4'b0010;
    hburst = HB_INCR4;
    cyc();
    check("t5_grant", bus_a.hgrant, 4'b0010);
    check("t5_lock", bus_a.hmastlock, 1);
    for (int b = 0; b < 4; b++) begin
      htrans = (b == 0) ? HT_NONSEQ : HT_SEQ;
      cyc();
    end
    check("t5_retained", bus_a.hgrant, 4'b0010);
    check("t5_lock_held", bus_a.hmastlock, 1);
    hlock  = 4'b0000;
    htrans = HT_NONSEQ;
    cyc();
    check("t5_unlock", bus_a.hmastlock, 0);
    htrans = HT_SEQ;
    cyc();
    cyc();
    check("t5_hold", bus_a.hgrant, 4'b0010);
    cyc();
    check("t5_handover", bus_a.hgrant, 4'b1000);
    check("t5_master", bus_a.hmaster, 3);

    // No-show timeout: master 0 idles 8 cycles, master 1 takes over
    apply_reset();
    hreq = 4'b0011;
    cyc();
    check("t6_grant", bus_a.hgrant, 4'b0001);
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("t6_tout", bus_a.hgrant, (i == 8) ? 4'b0010 : 4'b0001);
    end
    hreq = 4'b0000;
    cyc();
    check("t6_idle_grant", bus_a.hgrant, 0);
    check("t6_idle_hsel", bus_a.hsel, 0);

    // Open INCR capped at 16 beats, then early IDLE termination
    apply_reset();
    hreq   = 4'b0011;
    hburst = HB_INCR;
    cyc();
    htrans = HT_NONSEQ;
    cyc();
    htrans = HT_SEQ;
    for (int i = 0; i < 14; i++) cyc();
    check("t7_beat15", bus_a.hgrant, 4'b0001);
    cyc();
    check("t7_cap", bus_a.hgrant, 4'b0010);
    htrans = HT_NONSEQ;
    cyc();
    htrans = HT_SEQ;
    cyc();
    check("t7_mid", bus_a.hgrant, 4'b0010);
    htrans = HT_IDLE;
    cyc();
    check("t7_early_idle", bus_a.hgrant, 4'b0001);

    // Asynchronous reset mid-burst
    apply_reset();
    hreq   = 4'b0100;
    hburst = HB_INCR8;
    cyc();
    htrans = HT_NONSEQ;
    cyc();
    htrans = HT_SEQ;
    cyc();
    check("t8_pre", bus_a.hmaster, 2);
    #3;
    hreset_n = 1'b0;
    #1;
    check("t8_grant", bus_a.hgrant, 0);
    check("t8_master", bus_a.hmaster, 0);
    check("t8_hsel", bus_a.hsel, 0);
    #3;
    hreset_n = 1'b1;
    htrans   = HT_IDLE;
    cyc();
    check("t8_regrant", bus_a.hgrant, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
